// File: rtl/polyphonic_tone_generator_if.sv
// Control and audio-bit bundle between a tone sequencer (master) and the
// polyphonic tone generator (slave). Voice fields are packed voice 0 in the LSBs.
interface polyphonic_tone_generator_if #(
  parameter int NUM_VOICES   = 4,
  parameter int PERIOD_WIDTH = 24,
  parameter int VOL_WIDTH    = 3
);

  logic                               output_enable;
  logic [NUM_VOICES-1:0]              voice_enable;
  logic [NUM_VOICES*PERIOD_WIDTH-1:0] tone_switch_period;
  logic [NUM_VOICES*VOL_WIDTH-1:0]    volume;
  logic                               square_wave_out;

  modport master (
    output output_enable,
    output voice_enable,
    output tone_switch_period,
    output volume,
    input  square_wave_out
  );

  modport slave (
    input  output_enable,
    input  voice_enable,
    input  tone_switch_period,
    input  volume,
    output square_wave_out
  );

endinterface

// File: rtl/polyphonic_tone_generator.sv
// NUM_VOICES square-wave oscillators with per-voice volume, mixed and rendered
// onto a single pin by a first-order sigma-delta (PDM) modulator.
module polyphonic_tone_generator #(
  parameter int NUM_VOICES   = 4,
  parameter int PERIOD_WIDTH = 24,
  parameter int VOL_WIDTH    = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  polyphonic_tone_generator_if.slave   tone
);

  localparam int FS        = NUM_VOICES * ((1 << VOL_WIDTH) - 1);
  localparam int MIX_WIDTH = $clog2(2 * FS + 1);

  localparam logic [MIX_WIDTH-1:0] FULL_SCALE = MIX_WIDTH'(FS);

  logic [NUM_VOICES-1:0][VOL_WIDTH-1:0] amp;

  // ---------------------------------------------------------------------------
  // Oscillators
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_VOICES; gi++) begin : gen_voice
      logic [PERIOD_WIDTH-1:0] period;
      logic [VOL_WIDTH-1:0]    level;
      logic [PERIOD_WIDTH-1:0] cnt_reg;
      logic [PERIOD_WIDTH-1:0] cnt_next;
      logic                    ph_reg;
      logic                    ph_next;

      assign period = tone.tone_switch_period[gi*PERIOD_WIDTH +: PERIOD_WIDTH];
      assign level  = tone.volume[gi*VOL_WIDTH +: VOL_WIDTH];

      // Disable (or a zero period) takes priority over a pending toggle.
      // The >= compare lets a shrunk period wrap on the very next clock.
      always_comb begin
        cnt_next = cnt_reg + PERIOD_WIDTH'(1);
        ph_next  = ph_reg;
        if (!tone.voice_enable[gi] || (period == '0)) begin
          cnt_next = '0;
          ph_next  = 1'b0;
        end else if (cnt_reg >= (period - PERIOD_WIDTH'(1))) begin
          cnt_next = '0;
          ph_next  = ~ph_reg;
        end
      end

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_reg <= '0;
          ph_reg  <= 1'b0;
        end else begin
          cnt_reg <= cnt_next;
          ph_reg  <= ph_next;
        end
      end

      assign amp[gi] = ph_reg ? level : '0;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Mixer: one registered stage; MIX_WIDTH holds 2*FS, so no overflow here.
  // ---------------------------------------------------------------------------
  logic [MIX_WIDTH-1:0] mix_reg;
  logic [MIX_WIDTH-1:0] mix_next;

  always_comb begin
    mix_next = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      mix_next = mix_next + MIX_WIDTH'(amp[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mix_reg <= '0;
    end else begin
      mix_reg <= mix_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Sigma-delta modulator: acc stays in [0, FS), so acc + mix < 2*FS fits.
  // ---------------------------------------------------------------------------
  logic [MIX_WIDTH-1:0] acc_reg;
  logic [MIX_WIDTH-1:0] acc_next;
  logic [MIX_WIDTH-1:0] acc_sum;
  logic                 pdm_reg;
  logic                 pdm_next;

  assign acc_sum = acc_reg + mix_reg;

  always_comb begin
    acc_next = acc_sum;
    pdm_next = 1'b0;
    if (!tone.output_enable) begin
      acc_next = '0;
      pdm_next = 1'b0;
    end else if (acc_sum >= FULL_SCALE) begin
      acc_next = acc_sum - FULL_SCALE;
      pdm_next = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_reg <= '0;
      pdm_reg <= 1'b0;
    end else begin
      acc_reg <= acc_next;
      pdm_reg <= pdm_next;
    end
  end

  assign tone.square_wave_out = pdm_reg;

endmodule

// File: doc/polyphonic_tone_generator.md
# polyphonic_tone_generator

Parametrised, multi-voice successor to the single-voice tone generator. It runs up to NUM_VOICES independent square-wave oscillators, each with its own half-period and per-voice volume. It sums the voices and drives the 1-bit audio pin through a first-order sigma-delta modulator, so the pin's pulse density tracks the mixed amplitude. It sits between the music streamer (or any tone sequencer) and the audio output pin.

## Interface
- NUM_VOICES, 4: number of independent oscillators (≥1).
- PERIOD_WIDTH, 24: width of each voice's toggle period, in clocks.
- VOL_WIDTH, 3: width of each voice's volume level (unsigned).

- clk  input  1  system clock (125 MHz).
- rst  input  1  asynchronous, active-low reset.
- output_enable  input  1  1 = modulator runs; 0 = pin forced low.
- voice_enable  input  NUM_VOICES  per-voice enable; bit i gates voice i.
- tone_switch_period  input  NUM_VOICES*PERIOD_WIDTH  voice i in bits [i*PERIOD_WIDTH +: PERIOD_WIDTH]; clocks between phase toggles; 0 = silent.
- volume  input  NUM_VOICES*VOL_WIDTH  voice i in bits [i*VOL_WIDTH +: VOL_WIDTH].
- square_wave_out  output  1  sigma-delta PDM audio bit.

## Operation
- Full scale: FS = NUM_VOICES*(2^VOL_WIDTH-1). Mix and accumulator width = clog2(2*FS+1) bits; no overflow is possible.
- Per voice i, with counter cnt_i (PERIOD_WIDTH bits) and phase bit ph_i:
  - voice_enable[i]=0 or period_i=0: cnt_i<=0, ph_i<=0.
  - Otherwise, if cnt_i >= period_i-1: cnt_i<=0 and ph_i<=~ph_i. Else cnt_i<=cnt_i+1.
  - Phase therefore toggles every period_i clocks. The first toggle comes period_i clocks after enable.
  - Comparison is ≥, so shrinking the period below the current count wraps on the next clock.
- Voice amplitude a_i = ph_i ? volume_i : 0. Volume is sampled every cycle; it is not latched per period.
- Mix register: mix <= Σ a_i. This is registered, one stage.
- Modulator, with accumulator acc (0 ≤ acc < FS invariant):
  - output_enable=0: acc<=0, square_wave_out<=0.
  - Else with s = acc + mix: if s ≥ FS, then square_wave_out<=1 and acc<=s-FS. Else square_wave_out<=0 and acc<=s.
- Long-run density of square_wave_out equals mix/FS exactly. With mix=FS the output is constant 1; with mix=0 it is constant 0.
- Voices are independent. Any combination of enables, periods, and volumes is legal.

## Timing
- Reset (rst=0, async): every cnt_i=0, ph_i=0, mix=0, acc=0, square_wave_out=0. All stay held while rst=0.
- The first rising clk after rst deasserts is the first counting edge.
- Latency:
  - ph_i change at edge t → mix updated at edge t+1.
  - That mix first affects square_wave_out at edge t+2.
- output_enable falling: square_wave_out=0 from the next edge. Rising: modulator restarts from acc=0. Oscillators are unaffected either way.
- Simultaneous voice_enable[i] deassert and toggle condition: the disable wins (cnt_i=0, ph_i=0).
- Reset mid-tone: all state returns to reset values immediately, with no glitch beyond the async clear.
- No handshake. All inputs are sampled every clk edge and are synchronous to clk.

## Test plan
Use the defaults (FS=28) and count square_wave_out high cycles per 2500-clock window.
- Reset: drive voices active, pulse rst=0 mid-window.
  - Required: square_wave_out=0 and all counters 0 asynchronously.
  - First ph_0 toggle occurs period_0 clocks after release.
- Single voice: voice 0, period 4, volume 7, others disabled.
  - Required: ph_0 toggles every 4 clocks.
  - Over 2500-clock windows, count = 312 or 313 (density 7/28 × ½).
- Full-scale unison: all voices period 1250, volume 7.
  - Required: output constant 0 for the first 1250+2 clocks, then constant 1 for 1250.
  - Steady-state window count 1250.
- Silence paths, each checked with the others active at volume 7:
  - period_i=0 → a_i contributes 0.
  - voice_enable[i]=0 → a_i contributes 0.
  - All voices silent → count 0 for a full window.
- output_enable=0 for 1000 clocks with voices active.
  - Required: square_wave_out=0 throughout.
  - On re-enable, the modulator resumes with acc=0, and the oscillator phase continues uninterrupted.
- Period shrink: voice 0 at period 1000 with cnt=600, change period to 100.
  - Required: wrap and toggle on the next edge, then toggles every 100 clocks.
